// File: rtl/cfeb_hit_pkg.sv
// Shared sizing and state encoding for the chamber hit-scan sequencer.
package cfeb_hit_pkg;
    localparam int NCFEB  = 7;
    localparam int WIDTH  = 32;
    localparam int CNTW   = 8;
    localparam int TOTW   = 11;
    localparam int NLAYER = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/layer_popcount6.sv
// Combinational popcount of one CFEB's six layers of distrip hits.
module layer_popcount6
    import cfeb_hit_pkg::*;
#(
    parameter int WIDTH = cfeb_hit_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] l0,
    input  logic [WIDTH-1:0] l1,
    input  logic [WIDTH-1:0] l2,
    input  logic [WIDTH-1:0] l3,
    input  logic [WIDTH-1:0] l4,
    input  logic [WIDTH-1:0] l5,
    output logic [CNTW-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int b = 0; b < WIDTH; b++) begin
            cnt = cnt + CNTW'(l0[b]) + CNTW'(l1[b]) + CNTW'(l2[b])
                      + CNTW'(l3[b]) + CNTW'(l4[b]) + CNTW'(l5[b]);
        end
    end

endmodule

// File: rtl/cfeb_hit_scan_ctrl.sv
// Snapshots all CFEB layer hits on start, then walks one CFEB per clock through
// a single shared popcount, accumulating the chamber total and the busiest CFEB.
module cfeb_hit_scan_ctrl
    import cfeb_hit_pkg::*;
#(
    parameter int NCFEB = cfeb_hit_pkg::NCFEB,
    parameter int WIDTH = cfeb_hit_pkg::WIDTH,
    parameter int TOTW  = cfeb_hit_pkg::TOTW,
    parameter int IDXW  = (NCFEB > 1) ? $clog2(NCFEB) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NCFEB*WIDTH-1:0] ly0,
    input  logic [NCFEB*WIDTH-1:0] ly1,
    input  logic [NCFEB*WIDTH-1:0] ly2,
    input  logic [NCFEB*WIDTH-1:0] ly3,
    input  logic [NCFEB*WIDTH-1:0] ly4,
    input  logic [NCFEB*WIDTH-1:0] ly5,
    input  logic [NCFEB-1:0]       cfeb_en,
    input  logic [TOTW-1:0]        thresh,
    output logic                   busy,
    output logic                   done,
    output logic [TOTW-1:0]        total,
    output logic [CNTW-1:0]        max_cnt,
    output logic [IDXW-1:0]        max_idx,
    output logic                   over_thresh
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCFEB - 1);

    state_t state, state_nxt;

    logic [NCFEB*WIDTH-1:0] ly_in   [NLAYER];
    logic [WIDTH-1:0]       snap    [NCFEB][NLAYER];
    logic [NCFEB-1:0]       en_snap;
    logic [TOTW-1:0]        thresh_snap;

    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] sel;
    logic [TOTW-1:0] acc;
    logic [TOTW-1:0] sum;
    logic [CNTW-1:0] run_max;
    logic [IDXW-1:0] run_idx;
    logic [CNTW-1:0] pop;
    logic [CNTW-1:0] cnt;
    logic            last;
    logic            take;
    logic            accept;
    logic            step;

    assign ly_in[0] = ly0;
    assign ly_in[1] = ly1;
    assign ly_in[2] = ly2;
    assign ly_in[3] = ly3;
    assign ly_in[4] = ly4;
    assign ly_in[5] = ly5;

    assign accept = (state == IDLE) && start;
    assign step   = (state == SCAN) && !abort;
    assign last   = (idx == LAST_IDX);

    // idx only leaves 0..NCFEB-1 outside SCAN; clamp so the mux never reads past the snapshot
    assign sel = (idx <= LAST_IDX) ? idx : '0;

    layer_popcount6 #(.WIDTH(WIDTH)) u_pop (
        .l0  (snap[sel][0]),
        .l1  (snap[sel][1]),
        .l2  (snap[sel][2]),
        .l3  (snap[sel][3]),
        .l4  (snap[sel][4]),
        .l5  (snap[sel][5]),
        .cnt (pop)
    );

    assign cnt  = en_snap[sel] ? pop : '0;
    assign sum  = acc + TOTW'(cnt);
    assign take = (cnt > run_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Snapshot: the scan works only from these copies, so live inputs can change freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCFEB; k++) begin
                for (int l = 0; l < NLAYER; l++) begin
                    snap[k][l] <= '0;
                end
            end
            en_snap     <= '0;
            thresh_snap <= '0;
        end else if (accept) begin
            for (int k = 0; k < NCFEB; k++) begin
                for (int l = 0; l < NLAYER; l++) begin
                    snap[k][l] <= ly_in[l][k*WIDTH +: WIDTH];
                end
            end
            en_snap     <= cfeb_en;
            thresh_snap <= thresh;
        end
    end

    // Scan: accumulate, track the strictly-greater maximum, publish on the last CFEB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            acc         <= '0;
            run_max     <= '0;
            run_idx     <= '0;
            total       <= '0;
            max_cnt     <= '0;
            max_idx     <= '0;
            over_thresh <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            acc     <= '0;
            run_max <= '0;
            run_idx <= '0;
        end else if (step) begin
            acc <= sum;
            idx <= idx + 1'b1;
            if (take) begin
                run_max <= cnt;
                run_idx <= idx;
            end
            if (last) begin
                total       <= sum;
                max_cnt     <= take ? cnt : run_max;
                max_idx     <= take ? idx : run_idx;
                over_thresh <= (sum >= thresh_snap);
            end
        end
    end

endmodule

// File: tb/tb_cfeb_hit_scan_ctrl.sv
// Vector table plus scoreboard bench for the chamber hit-scan sequencer.
module tb_cfeb_hit_scan_ctrl;

    localparam int NC = 7;
    localparam int W  = 32;
    localparam int BW = NC * W;

    typedef struct {
        logic [BW-1:0] ly [6];
        logic [NC-1:0] en;
        logic [10:0]   thresh;
        int            e_total;
        int            e_max;
        int            e_idx;
        int            e_over;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] ly0 = '0, ly1 = '0, ly2 = '0, ly3 = '0, ly4 = '0, ly5 = '0;
    logic [NC-1:0] cfeb_en = '0;
    logic [10:0]   thresh = '0;
    logic          busy, done, over_thresh;
    logic [10:0]   total;
    logic [7:0]    max_cnt;
    logic [2:0]    max_idx;

    int checks = 0;
    int errors = 0;
    vec_t sb_q[$];
    vec_t tbl[6];

    cfeb_hit_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ly0(ly0), .ly1(ly1), .ly2(ly2), .ly3(ly3), .ly4(ly4), .ly5(ly5),
        .cfeb_en(cfeb_en), .thresh(thresh),
        .busy(busy), .done(done), .total(total), .max_cnt(max_cnt),
        .max_idx(max_idx), .over_thresh(over_thresh)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int c;
        r.e_total = 0; r.e_max = 0; r.e_idx = 0;
        for (int k = 0; k < NC; k++) begin
            c = 0;
            if (v.en[k]) for (int l = 0; l < 6; l++) c += $countones(v.ly[l][k*W +: W]);
            r.e_total += c;
            if (c > r.e_max) begin r.e_max = c; r.e_idx = k; end
        end
        r.e_over = (r.e_total >= int'(v.thresh)) ? 1 : 0;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        ly0 = v.ly[0]; ly1 = v.ly[1]; ly2 = v.ly[2];
        ly3 = v.ly[3]; ly4 = v.ly[4]; ly5 = v.ly[5];
        cfeb_en = v.en; thresh = v.thresh;
    endtask

    task automatic check_result(input string nm);
        vec_t e;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_total"}, int'(total), e.e_total);
            chk({nm, "_max_cnt"}, int'(max_cnt), e.e_max);
            chk({nm, "_max_idx"}, int'(max_idx), e.e_idx);
            chk({nm, "_over"}, int'(over_thresh), e.e_over);
        end
    endtask

    // Called one step after the start edge; returns edges elapsed until done and busy-cycle count
    task automatic wait_done(output int lat, output int nbusy);
        lat = -1;
        nbusy = 0;
        for (int c = 0; c <= 20; c++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_scan(input vec_t v, input string nm);
        int lat, nbusy;
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(v);
        wait_done(lat, nbusy);
        chk({nm, "_latency"}, lat, 7);
        if (lat < 0) begin
            void'(sb_q.pop_front());
        end else begin
            chk({nm, "_busy_cycles"}, nbusy, 8);
            check_result(nm);
            @(posedge clk); #1;
            chk({nm, "_busy_after"}, int'(busy), 0);
            chk({nm, "_done_after"}, int'(done), 0);
        end
    endtask

    task automatic quiet(input int n, input string nm);
        int nd = 0, nb = 0;
        for (int c = 0; c < n; c++) begin
            if (done) nd++;
            if (busy) nb++;
            @(posedge clk); #1;
        end
        chk({nm, "_no_done"}, nd, 0);
        chk({nm, "_no_busy"}, nb, 0);
    endtask

    initial begin
        vec_t zero_v, ones_v, p3_v, rnd_v;
        int lat, nbusy;

        for (int l = 0; l < 6; l++) begin
            zero_v.ly[l] = '0;
            ones_v.ly[l] = '1;
            p3_v.ly[l] = '0;
            p3_v.ly[l][160] = 1'b1;
            rnd_v.ly[l] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        p3_v.ly[1][105:96] = 10'h3FF;

        tbl[0] = zero_v; tbl[0].en = 7'h7F; tbl[0].thresh = 11'd1;
        tbl[0].e_total = 0; tbl[0].e_max = 0; tbl[0].e_idx = 0; tbl[0].e_over = 0;
        tbl[1] = ones_v; tbl[1].en = 7'h7F; tbl[1].thresh = 11'd1344;
        tbl[1].e_total = 1344; tbl[1].e_max = 192; tbl[1].e_idx = 0; tbl[1].e_over = 1;
        tbl[2] = tbl[1]; tbl[2].thresh = 11'd1345; tbl[2].e_over = 0;
        tbl[3] = p3_v; tbl[3].en = 7'h7F; tbl[3].thresh = 11'd16;
        tbl[3].e_total = 16; tbl[3].e_max = 10; tbl[3].e_idx = 3; tbl[3].e_over = 1;
        tbl[4] = p3_v; tbl[4].en = 7'h77; tbl[4].thresh = 11'd16;
        tbl[4].e_total = 6; tbl[4].e_max = 6; tbl[4].e_idx = 5; tbl[4].e_over = 0;
        rnd_v.en = 7'h5B; rnd_v.thresh = 11'd500;
        tbl[5] = model(rnd_v);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_max_cnt", int'(max_cnt), 0);
        chk("rst_max_idx", int'(max_idx), 0);
        chk("rst_over", int'(over_thresh), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_scan(tbl[i], $sformatf("vec%0d", i));

        // Inputs change and start re-pulses while busy: snapshot governs, no second scan
        drive(tbl[3]);
        start = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back(tbl[3]);
        drive(ones_v);
        wait_done(lat, nbusy);
        chk("snap_latency", lat, 7);
        if (lat >= 0) check_result("snap");
        @(posedge clk); #1;
        start = 1'b0;
        chk("snap_busy_after", int'(busy), 0);
        quiet(10, "snap");

        // Abort on the third SCAN cycle keeps the previous results
        drive(ones_v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_total_kept", int'(total), 16);
        chk("abort_max_cnt_kept", int'(max_cnt), 10);
        chk("abort_max_idx_kept", int'(max_idx), 3);
        chk("abort_over_kept", int'(over_thresh), 1);
        quiet(10, "abort");
        run_scan(tbl[1], "post_abort");

        // Reset mid-scan
        drive(zero_v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_total", int'(total), 0);
        chk("mrst_max_cnt", int'(max_cnt), 0);
        chk("mrst_max_idx", int'(max_idx), 0);
        chk("mrst_over", int'(over_thresh), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet(10, "mrst");
        run_scan(tbl[5], "post_rst");

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfeb_hit_scan_ctrl.md
Name: cfeb_hit_scan_ctrl

Overview:
- Sequencer that shares one six-layer popcount datapath across all CFEBs of a chamber.
- On a start request it snapshots the layer hit bits of every CFEB, then scans one CFEB per clock through a single shared popcount.
- It accumulates the chamber total and tracks the busiest CFEB, then reports the result with a one-cycle done pulse.
- Sits between the triad-decoded hit staging and the pattern-finder occupancy/threshold logic.

Parameters:
- NCFEB, 7, number of CFEBs scanned.
- WIDTH, 32, distrips per layer per CFEB.
- TOTW, 11, width of the chamber total; must hold NCFEB*6*WIDTH (1344 at defaults).

Ports:
- clk, in, 1, single system clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, scan request; sampled only while busy=0.
- abort, in, 1, synchronous cancel of an in-progress scan.
- ly0..ly5, in, NCFEB*WIDTH each, per-layer hits; CFEB k occupies bits [k*WIDTH +: WIDTH].
- cfeb_en, in, NCFEB, per-CFEB enable; a disabled CFEB counts as 0.
- thresh, in, TOTW, occupancy threshold.
- busy, out, 1, high from the cycle after start is accepted until done falls.
- done, out, 1, one-cycle pulse marking that the result ports have updated.
- total, out, TOTW, chamber hit count.
- max_cnt, out, 8, largest per-CFEB count (max 192).
- max_idx, out, 3, CFEB index of max_cnt.
- over_thresh, out, 1, total >= thresh.

Behaviour:
- Async reset (rst_n=0):
  - state=IDLE.
  - busy, done, total, max_cnt, max_idx and over_thresh are all 0.
  - Snapshot registers are cleared.
- States: IDLE, SCAN, DONE. busy = (state != IDLE).
- IDLE:
  - On start=1, capture ly0..ly5, cfeb_en and thresh into snapshot registers.
  - Clear idx, acc and run_max/run_idx; go to SCAN.
  - start=0 leaves the state at IDLE.
- SCAN, each clock:
  - cnt = popcount of the 6x WIDTH bits of snapshot CFEB idx, forced to 0 if en_snap[idx]=0.
  - acc += cnt.
  - If cnt > run_max (strictly greater), run_max = cnt and run_idx = idx; ties keep the lower index.
  - idx++.
  - On the edge that processes idx = NCFEB-1:
    - Load total = final acc, max_cnt = run_max, max_idx = run_idx.
    - Load over_thresh = (final acc >= thresh_snap).
    - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - With start sampled at edge E0, done is high in the cycle after edge E(NCFEB), i.e. edge E7 at defaults.
  - Earliest next accepted start is the cycle after done.
- Result ports hold their values until the next DONE; done is the only pulse.
- Inputs are not retimed: input changes after the start edge have no effect on the running scan.
- start while busy (SCAN or DONE) is ignored; it is not queued.
- abort=1 in SCAN:
  - Return to IDLE next edge, with no done.
  - Result ports keep their previous values.
- abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-scan behaves as a full reset, with no done.
- Arithmetic:
  - cnt is 8 bits, zero-extended into the TOTW-bit acc.
  - acc cannot overflow at the parameterised widths.

Decomposition:
- Package cfeb_hit_pkg holds:
  - Localparams NCFEB, WIDTH, CNTW=8, TOTW.
  - The state encoding enum for IDLE/SCAN/DONE.
- One combinational sub-module, layer_popcount6: six WIDTH-bit inputs → 8-bit count.
  - Instantiated once and fed through the idx-driven mux.
- The controller contains the FSM, the snapshot, the mux, the accumulator and the max tracker.

Test Plan:
1. All layers zero, cfeb_en=7'h7F, thresh=1, start pulse → done exactly 8 cycles after the start edge; total=0, max_cnt=0, max_idx=0, over_thresh=0, busy high for 8 cycles.
2. All layers all ones, cfeb_en=7'h7F, thresh=1344 → total=1344, max_cnt=192, max_idx=0 (tie rule), over_thresh=1. Repeat with thresh=1345 → over_thresh=0.
3. CFEB3 ly1 bits 0..9 set, CFEB5 bit 0 set on all six layers:
   - cfeb_en=7'h7F → total=16, max_cnt=10, max_idx=3.
   - cfeb_en=7'h77 → total=6, max_cnt=6, max_idx=5.
4. Start accepted, then hits changed to all ones and extra start pulses applied during SCAN/DONE → result matches the snapshot; exactly one done, no second scan.
5. abort asserted on the 3rd SCAN cycle → busy falls next cycle, no done, result ports keep the prior scan's values; a new start then completes normally.
6. rst_n low for 1 cycle mid-SCAN → all outputs read 0 and busy=0 immediately; no done follows.
